// File: rtl/tc_var_delay_line.sv
// Variable-depth delay line: MAX_DEPTH register stages with per-stage valid bits,
// output tapped at a run-time selectable depth.
module tc_var_delay_line #(
    parameter int unsigned BIT_WIDTH = 1,
    parameter int unsigned MAX_DEPTH = 2,
    localparam int unsigned DW       = $clog2(MAX_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic [DW-1:0]        delay,
    input  logic [BIT_WIDTH-1:0] in,
    input  logic                 in_valid,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic [DW-1:0]        fill
);

    localparam logic [DW-1:0] MaxDepthW = DW'(MAX_DEPTH);

    logic [BIT_WIDTH-1:0] stage_q [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] valid_q;
    logic [DW-1:0]        tap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (en) begin
            // Data shifts regardless of in_valid; the valid bits travel alongside.
            stage_q[0] <= in;
            valid_q[0] <= in_valid;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Tap index is D-1, with delay 0 mapping to the first stage and oversize requests clamped.
    always_comb begin
        tap = '0;
        if (delay == '0) begin
            tap = '0;
        end else if (delay > MaxDepthW) begin
            tap = MaxDepthW - DW'(1);
        end else begin
            tap = delay - DW'(1);
        end
    end

    always_comb begin
        out       = '0;
        out_valid = 1'b0;
        fill      = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DW'(i) == tap) begin
                out       = stage_q[i];
                out_valid = valid_q[i];
            end
            if (DW'(i) <= tap && valid_q[i]) begin
                fill = fill + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tc_var_delay_line.sv
// Directed bench for tc_var_delay_line with MAX_DEPTH=4, BIT_WIDTH=8.
module tb_tc_var_delay_line;

    localparam int unsigned BW = 8;
    localparam int unsigned MD = 4;
    localparam int unsigned DW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          flush;
    logic [DW-1:0] delay;
    logic [BW-1:0] in;
    logic          in_valid;
    logic [BW-1:0] out;
    logic          out_valid;
    logic [DW-1:0] fill;

    int errors;
    int checks;

    tc_var_delay_line #(
        .BIT_WIDTH(BW),
        .MAX_DEPTH(MD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .delay    (delay),
        .in       (in),
        .in_valid (in_valid),
        .out      (out),
        .out_valid(out_valid),
        .fill     (fill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          en;
        logic          flush;
        logic [DW-1:0] delay;
        logic [BW-1:0] din;
        logic          dv;
        logic [BW-1:0] exp_out;
        logic          exp_ov;
        logic [DW-1:0] exp_fill;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [BW-1:0] eo, input logic eov,
                             input logic [DW-1:0] ef);
        check({name, " out"}, int'(out), int'(eo));
        check({name, " out_valid"}, int'(out_valid), int'(eov));
        check({name, " fill"}, int'(fill), int'(ef));
    endtask

    task automatic step(input logic e, input logic f, input logic [DW-1:0] d,
                        input logic [BW-1:0] di, input logic dv);
        en = e; flush = f; delay = d; in = di; in_valid = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; en = 1'b0; flush = 1'b0; delay = 3'd3; in = '0; in_valid = 1'b0;

        //           en  fl  dly   in     v    out    ov   fill
        vecs[0]  = '{1'b1, 1'b0, 3'd3, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1};
        vecs[1]  = '{1'b1, 1'b0, 3'd3, 8'h22, 1'b1, 8'h00, 1'b0, 3'd2};
        vecs[2]  = '{1'b1, 1'b0, 3'd3, 8'h33, 1'b1, 8'h11, 1'b1, 3'd3};
        vecs[3]  = '{1'b1, 1'b0, 3'd3, 8'h44, 1'b0, 8'h22, 1'b1, 3'd2};
        vecs[4]  = '{1'b1, 1'b0, 3'd3, 8'h55, 1'b0, 8'h33, 1'b1, 3'd1};
        vecs[5]  = '{1'b0, 1'b0, 3'd3, 8'h66, 1'b1, 8'h33, 1'b1, 3'd1};
        vecs[6]  = '{1'b1, 1'b1, 3'd3, 8'h77, 1'b1, 8'h00, 1'b0, 3'd0};
        vecs[7]  = '{1'b1, 1'b0, 3'd0, 8'h9A, 1'b1, 8'h9A, 1'b1, 3'd1};
        vecs[8]  = '{1'b1, 1'b0, 3'd7, 8'hBC, 1'b1, 8'h00, 1'b0, 3'd2};
        vecs[9]  = '{1'b1, 1'b0, 3'd7, 8'hDE, 1'b1, 8'h00, 1'b0, 3'd3};
        vecs[10] = '{1'b1, 1'b0, 3'd7, 8'hF0, 1'b1, 8'h9A, 1'b1, 3'd4};
        vecs[11] = '{1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 8'h9A, 1'b1, 3'd4};
        vecs[12] = '{1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 8'hF0, 1'b1, 3'd1};
        vecs[13] = '{1'b1, 1'b0, 3'd2, 8'h01, 1'b0, 8'hF0, 1'b1, 3'd1};

        #2;
        check_all("reset", 8'h00, 1'b0, 3'd0);
        #10;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].en, vecs[i].flush, vecs[i].delay, vecs[i].din, vecs[i].dv);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_ov, vecs[i].exp_fill);
        end

        // Flush with all stages holding 0xAA.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'd4, 8'hAA, 1'b1);
        check_all("aa_loaded", 8'hAA, 1'b1, 3'd4);
        step(1'b1, 1'b1, 3'd4, 8'h55, 1'b1);
        check_all("aa_flush", 8'h00, 1'b0, 3'd0);

        // Enable gap of two cycles between samples at delay 3.
        step(1'b1, 1'b0, 3'd3, 8'h11, 1'b1);
        check_all("gap_e1", 8'h00, 1'b0, 3'd1);
        step(1'b0, 1'b0, 3'd3, 8'h99, 1'b1);
        check_all("gap_hold1", 8'h00, 1'b0, 3'd1);
        step(1'b0, 1'b0, 3'd3, 8'h99, 1'b1);
        check_all("gap_hold2", 8'h00, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd3, 8'h22, 1'b1);
        check_all("gap_e2", 8'h00, 1'b0, 3'd2);
        step(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
        check_all("gap_e3", 8'h11, 1'b1, 3'd2);
        step(1'b0, 1'b0, 3'd3, 8'h00, 1'b0);
        check_all("gap_hold3", 8'h11, 1'b1, 3'd2);
        step(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
        check_all("gap_e4", 8'h22, 1'b1, 3'd1);

        // Live delay switch with three valid samples in flight.
        step(1'b1, 1'b1, 3'd4, 8'h00, 1'b0);
        step(1'b1, 1'b0, 3'd4, 8'hA1, 1'b1);
        step(1'b1, 1'b0, 3'd4, 8'hA2, 1'b1);
        step(1'b1, 1'b0, 3'd4, 8'hA3, 1'b1);
        en = 1'b0;
        #1;
        check_all("sw_d4", 8'h00, 1'b0, 3'd3);
        delay = 3'd1;
        #1;
        check_all("sw_d1", 8'hA3, 1'b1, 3'd1);
        delay = 3'd3;
        #1;
        check_all("sw_d3", 8'hA1, 1'b1, 3'd3);
        delay = 3'd4;
        #1;
        check_all("sw_back4", 8'h00, 1'b0, 3'd3);

        // Asynchronous reset between edges, then a fresh sample at delay 2.
        delay = 3'd1;
        @(posedge clk);
        #2;
        check_all("pre_rst", 8'hA3, 1'b1, 3'd1);
        rst = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 1'b0, 3'd0);
        delay = 3'd3;
        #1;
        check_all("async_rst_d3", 8'h00, 1'b0, 3'd0);
        rst = 1'b0;
        step(1'b1, 1'b0, 3'd2, 8'h5A, 1'b1);
        check_all("post_rst_e1", 8'h00, 1'b0, 3'd1);
        step(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
        check_all("post_rst_e2", 8'h5A, 1'b1, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tc_var_delay_line.md
TC_VAR_DELAY_LINE -- requirements
Module: tc_var_delay_line

Interface
REQ-001 The module SHALL have the parameter BIT_WIDTH, default 1, giving the data width in bits.
REQ-002 The module SHALL have the parameter MAX_DEPTH, default 2, giving the number of register stages (legal 1..256).
REQ-003 The module SHALL have the derived parameter DW = ceil(log2(MAX_DEPTH+1)), giving the width of the delay port.
REQ-004 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port en  input  1  shift enable; 0 = hold all stages.
REQ-007 Port flush  input  1  synchronous clear of all stages.
REQ-008 Port delay  input  DW  selected latency in enabled cycles.
REQ-009 Port in  input  BIT_WIDTH  data input.
REQ-010 Port in_valid  input  1  qualifies in.
REQ-011 Port out  output  BIT_WIDTH  delayed data.
REQ-012 Port out_valid  output  1  delayed in_valid.
REQ-013 Port fill  output  DW  count of valid stages within the selected depth, saturating.

Function
REQ-014 The module SHALL hold MAX_DEPTH data stages S[0..MAX_DEPTH-1], each with a valid bit V[i].
REQ-015 On a posedge with en=1 and flush=0, the module SHALL load S[0]<=in and V[0]<=in_valid, and shift S[i]<=S[i-1] and V[i]<=V[i-1] for i>=1.
REQ-016 On a posedge with en=0 and flush=0, all stages SHALL hold their values.
REQ-017 On a posedge with flush=1, all S and V SHALL clear to 0 regardless of en, and in is discarded.
REQ-018 The effective delay D SHALL be computed from the delay port as follows:
- delay=0 gives D=1.
- delay>MAX_DEPTH gives D=MAX_DEPTH.
- otherwise D=delay.
REQ-019 The module SHALL drive out=S[D-1] and out_valid=V[D-1] combinationally from registered state, with no path from in to out.
REQ-020 Latency SHALL be as follows: a sample accepted on enabled edge k SHALL appear on out immediately after the (k+D-1)th enabled edge, i.e. after D enabled edges in total; disabled cycles do not count.
REQ-021 A change of delay SHALL take effect in the same cycle; the output then shows the selected tap's current content, including its valid bit, with no drain or refill sequencing.
REQ-022 The fill output SHALL equal the number of set V[i] for i<D, updated from registered state.
REQ-023 When en=1 and flush=1 on the same edge, flush SHALL take priority.
REQ-024 With MAX_DEPTH=2, delay=2, en=1, flush=0, the module SHALL be cycle-equivalent to the existing two-stage delay line on out.
REQ-025 Stage contents SHALL never be gated by in_valid; data SHALL shift even when in_valid=0, so that out_valid alone marks meaningful data.

Reset
REQ-026 While rst=1, asynchronously and independent of clk, all S[i] SHALL be 0 and all V[i] SHALL be 0; out, out_valid and fill SHALL therefore be 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight samples, with no partial shift.
REQ-028 The first enabled edge after rst deasserts SHALL behave as a normal shift.

Verification
REQ-029 Scenario: MAX_DEPTH=4, BIT_WIDTH=8, delay=3, en=1; drive in=0x11,0x22,0x33 with in_valid=1 on edges 1..3. Required: out=0x11 with out_valid=1 after edge 3, 0x22 after edge 4, and 0x33 after edge 5.
REQ-030 Scenario: same setup; deassert en for 2 cycles between samples 0x11 and 0x22. Required: the 0x22 output is delayed by exactly 2 extra cycles and out holds stable while en=0.
REQ-031 Scenario: load 0xAA into all 4 stages, then pulse flush with en=1 and in=0x55. Required: after that edge out=0, out_valid=0 and fill=0.
REQ-032 Scenario: delay=0 and delay=7 with MAX_DEPTH=4. Required: the latency equals that of delay=1 and delay=4 respectively.
REQ-033 Scenario: with 3 valid samples in flight, switch delay from 4 to 1. Required: in the same cycle out=S[0] and fill=1; after switching back to 4, the old tap S[3] is visible with its valid bit.
REQ-034 Scenario: assert rst between clock edges with valid data present. Required: out=0, out_valid=0 and fill=0 before the next posedge; after release, a sample 0x5A with delay=2 appears after 2 enabled edges.
